// File: rtl/trap_entry_seq.sv
// -----------------------------------------------------------------------------
// trap_entry_seq
//
// SPARC trap-entry sequencer. It sits behind the trap-type encoder, takes the
// encoded 3-bit trap index and steps the processor through trap entry:
// PSR update (ET<-0, PS<-S, S<-1, CWP<-CWP-1), saving PC/nPC into l1/l2
// (r17/r18) of the new window, loading TBR.tt and redirecting PC/nPC to the
// trap vector. A trap that arrives with ET=0 puts the core into error mode,
// which only reset clears.
//
// Optional feature (macro TRAP_ENTRY_SEQ_COUNT_EN): adds a saturating 16-bit
// count of accepted traps on output trap_count.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   trap_valid        encoder request, held until accept
//   trap_idx          encoded trap index
//   et                PSR.ET, sampled only while idle
//   cwp               current PSR.CWP
//   pc, npc           PC/nPC of the trapped instruction
//   tba               TBR.TBA field
//   accept            combinational pulse: trap taken this cycle
//   busy              high while a trap-entry sequence is running
//   psr_we/new_cwp    PSR update strobe and decremented CWP
//   rf_we/rf_waddr/rf_wdata   register-file write port (window-relative)
//   tbr_we/tbr_tt     TBR.tt write strobe and trap type
//   pc_we/pc_out/npc_out      PC/nPC redirect to the trap vector
//   done              pulse in the final (vector) cycle
//   error_mode        sticky error-mode flag
//   trap_count        accepted-trap count (only with TRAP_ENTRY_SEQ_COUNT_EN)
// -----------------------------------------------------------------------------
module trap_entry_seq #(
  parameter int NWINDOWS = 8,
  parameter int CWPW     = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trap_valid,
  input  logic [2:0]      trap_idx,
  input  logic            et,
  input  logic [CWPW-1:0] cwp,
  input  logic [31:0]     pc,
  input  logic [31:0]     npc,
  input  logic [19:0]     tba,
  output logic            accept,
  output logic            busy,
  output logic            psr_we,
  output logic [CWPW-1:0] new_cwp,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic            tbr_we,
  output logic [7:0]      tbr_tt,
  output logic            pc_we,
  output logic [31:0]     pc_out,
  output logic [31:0]     npc_out,
  output logic            done,
  output logic            error_mode
`ifdef TRAP_ENTRY_SEQ_COUNT_EN
  ,
  output logic [15:0]     trap_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_SAVE_L1,
    S_SAVE_L2,
    S_VECTOR,
    S_ERROR
  } state_t;

  state_t          r_state;

  // Trap context captured at accept
  logic [2:0]      r_idx;
  logic [31:0]     r_pc;
  logic [31:0]     r_npc;
  logic [19:0]     r_tba;

  // Registered outputs
  logic            r_busy;
  logic            r_psr_we;
  logic [CWPW-1:0] r_new_cwp;
  logic            r_rf_we;
  logic [4:0]      r_rf_waddr;
  logic [31:0]     r_rf_wdata;
  logic            r_tbr_we;
  logic [7:0]      r_tbr_tt;
  logic            r_pc_we;
  logic [31:0]     r_pc_out;
  logic [31:0]     r_npc_out;
  logic            r_done;
  logic            r_error;

  logic            w_take;
  logic [CWPW-1:0] w_cwp_dec;
  logic [7:0]      w_tt;
  logic [31:0]     w_vec;

  assign w_take    = (r_state == S_IDLE) && trap_valid && et;
  // Window decrement wraps from 0 to the top window
  assign w_cwp_dec = (cwp == '0) ? CWPW'(NWINDOWS - 1) : cwp - CWPW'(1);
  assign w_tt      = {5'b00000, r_idx};
  assign w_vec     = {r_tba, w_tt, 4'b0000};

  // accept is combinational; gate it so every output reads 0 during reset
  assign accept     = w_take && !reset;
  assign busy       = r_busy;
  assign psr_we     = r_psr_we;
  assign new_cwp    = r_new_cwp;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign tbr_we     = r_tbr_we;
  assign tbr_tt     = r_tbr_tt;
  assign pc_we      = r_pc_we;
  assign pc_out     = r_pc_out;
  assign npc_out    = r_npc_out;
  assign done       = r_done;
  assign error_mode = r_error;

  // Outputs are loaded on the edge that enters the state they belong to, so
  // each strobe and its data are visible for exactly that state's cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_pc       <= '0;
      r_npc      <= '0;
      r_tba      <= '0;
      r_busy     <= 1'b0;
      r_psr_we   <= 1'b0;
      r_new_cwp  <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_tbr_we   <= 1'b0;
      r_tbr_tt   <= '0;
      r_pc_we    <= 1'b0;
      r_pc_out   <= '0;
      r_npc_out  <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_psr_we   <= 1'b0;
      r_new_cwp  <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_tbr_we   <= 1'b0;
      r_tbr_tt   <= '0;
      r_pc_we    <= 1'b0;
      r_pc_out   <= '0;
      r_npc_out  <= '0;
      r_done     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (trap_valid) begin
            if (et) begin
              r_idx     <= trap_idx;
              r_pc      <= pc;
              r_npc     <= npc;
              r_tba     <= tba;
              r_state   <= S_ENTER;
              r_busy    <= 1'b1;
              r_psr_we  <= 1'b1;
              r_new_cwp <= w_cwp_dec;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
        S_ENTER: begin
          r_state    <= S_SAVE_L1;
          r_rf_we    <= 1'b1;
          r_rf_waddr <= 5'd17;
          r_rf_wdata <= r_pc;
        end
        S_SAVE_L1: begin
          r_state    <= S_SAVE_L2;
          r_rf_we    <= 1'b1;
          r_rf_waddr <= 5'd18;
          r_rf_wdata <= r_npc;
        end
        S_SAVE_L2: begin
          r_state   <= S_VECTOR;
          r_tbr_we  <= 1'b1;
          r_tbr_tt  <= w_tt;
          r_pc_we   <= 1'b1;
          r_pc_out  <= w_vec;
          r_npc_out <= w_vec + 32'd4;
          r_done    <= 1'b1;
        end
        S_VECTOR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_ERROR: begin
          r_state <= S_ERROR;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRAP_ENTRY_SEQ_COUNT_EN
  logic [15:0] r_count;

  // Saturating count of taken traps; error-mode entry is not a taken trap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_take && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign trap_count = r_count;
`endif

endmodule

// File: tb/tb_trap_entry_seq.sv
module tb_trap_entry_seq;

  localparam int NW = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          trap_valid = 1'b0;
  logic [2:0]    trap_idx = '0;
  logic          et = 1'b0;
  logic [CW-1:0] cwp = '0;
  logic [31:0]   pc = '0;
  logic [31:0]   npc = '0;
  logic [19:0]   tba = '0;
  logic          accept, busy, psr_we, rf_we, tbr_we, pc_we, done, error_mode;
  logic [CW-1:0] new_cwp;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata, pc_out, npc_out;
  logic [7:0]    tbr_tt;
`ifdef TRAP_ENTRY_SEQ_COUNT_EN
  logic [15:0]   trap_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trap_entry_seq #(.NWINDOWS(NW), .CWPW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .trap_valid (trap_valid),
    .trap_idx   (trap_idx),
    .et         (et),
    .cwp        (cwp),
    .pc         (pc),
    .npc        (npc),
    .tba        (tba),
    .accept     (accept),
    .busy       (busy),
    .psr_we     (psr_we),
    .new_cwp    (new_cwp),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .tbr_we     (tbr_we),
    .tbr_tt     (tbr_tt),
    .pc_we      (pc_we),
    .pc_out     (pc_out),
    .npc_out    (npc_out),
    .done       (done),
    .error_mode (error_mode)
`ifdef TRAP_ENTRY_SEQ_COUNT_EN
    ,
    .trap_count (trap_count)
`endif
  );

  typedef struct packed {
    logic          accept;
    logic          busy;
    logic          psr_we;
    logic [CW-1:0] new_cwp;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          tbr_we;
    logic [7:0]    tbr_tt;
    logic          pc_we;
    logic [31:0]   pc_out;
    logic [31:0]   npc_out;
    logic          done;
    logic          error_mode;
  } obs_t;

  typedef struct {
    logic [2:0]    idx;
    logic [CW-1:0] cwp;
    logic [31:0]   pc;
    logic [31:0]   npc;
    logic [19:0]   tba;
    logic [CW-1:0] exp_cwp;
    logic [7:0]    exp_tt;
    logic [31:0]   exp_pc;
    logic [31:0]   exp_npc;
  } vec_t;

  vec_t tbl[4];

  // Reference: expected trap results from the architectural rules
  function automatic vec_t ref_vec(input logic [2:0] idx, input logic [CW-1:0] c,
                                   input logic [31:0] p, input logic [31:0] np,
                                   input logic [19:0] b);
    vec_t v;
    int   wnd;
    v.idx = idx; v.cwp = c; v.pc = p; v.npc = np; v.tba = b;
    wnd       = (int'(c) + NW - 1) % NW;
    v.exp_cwp = CW'(wnd);
    v.exp_tt  = {5'd0, idx};
    v.exp_pc  = {12'd0, b} * 32'd4096 + {29'd0, idx} * 32'd16;
    v.exp_npc = v.exp_pc + 32'd4;
    return v;
  endfunction

  // Expected observation k cycles after the accept cycle (k=0 is accept)
  function automatic obs_t expect_at(input int k, input vec_t v);
    obs_t e = '0;
    case (k)
      0: e.accept = 1'b1;
      1: begin e.busy = 1'b1; e.psr_we = 1'b1; e.new_cwp = v.exp_cwp; end
      2: begin e.busy = 1'b1; e.rf_we = 1'b1; e.rf_waddr = 5'd17; e.rf_wdata = v.pc; end
      3: begin e.busy = 1'b1; e.rf_we = 1'b1; e.rf_waddr = 5'd18; e.rf_wdata = v.npc; end
      4: begin
        e.busy = 1'b1; e.tbr_we = 1'b1; e.tbr_tt = v.exp_tt;
        e.pc_we = 1'b1; e.pc_out = v.exp_pc; e.npc_out = v.exp_npc; e.done = 1'b1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic obs_t sample_dut();
    obs_t o;
    o.accept = accept; o.busy = busy; o.psr_we = psr_we; o.new_cwp = new_cwp;
    o.rf_we = rf_we; o.rf_waddr = rf_waddr; o.rf_wdata = rf_wdata;
    o.tbr_we = tbr_we; o.tbr_tt = tbr_tt; o.pc_we = pc_we;
    o.pc_out = pc_out; o.npc_out = npc_out; o.done = done; o.error_mode = error_mode;
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t got;
    got = sample_dut();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Compare at the falling edge, then move to just after the next rising edge
  task automatic step(input string name, input obs_t exp);
    @(negedge clk);
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_trap(input vec_t v);
    trap_valid = 1'b1; et = 1'b1;
    trap_idx = v.idx; cwp = v.cwp; pc = v.pc; npc = v.npc; tba = v.tba;
  endtask

  // Random noise on the context inputs; the sequencer must have latched them
  task automatic drive_junk();
    trap_valid = 1'b0;
    et         = 1'($urandom);
    trap_idx   = 3'($urandom);
    cwp        = CW'($urandom_range(0, NW - 1));
    pc         = $urandom;
    npc        = $urandom;
    tba        = 20'($urandom);
  endtask

  task automatic run_trap(input string name, input vec_t v);
    drive_trap(v);
    step($sformatf("%s_k0", name), expect_at(0, v));
    drive_junk();
    for (int k = 1; k <= 5; k++) step($sformatf("%s_k%0d", name, k), expect_at(k, v));
  endtask

  task automatic do_reset();
    reset = 1'b1; trap_valid = 1'b1; et = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step("reset_state", obs_t'(0));
    reset = 1'b0; trap_valid = 1'b0;
  endtask

  function automatic vec_t rand_vec();
    return ref_vec(3'($urandom), CW'($urandom_range(0, NW - 1)), $urandom, $urandom,
                   20'($urandom));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t e_err;
    vec_t v1, v2;

    tbl[0] = '{3'd3, 5'd2, 32'h0000_0100, 32'h0000_0104, 20'h00040,
               5'd1, 8'h03, 32'h0004_0030, 32'h0004_0034};
    tbl[1] = '{3'd5, 5'd0, 32'h0000_2000, 32'h0000_2004, 20'h12345,
               5'd7, 8'h05, 32'h1234_5050, 32'h1234_5054};
    tbl[2] = '{3'd7, 5'd7, 32'hFFFF_FFFC, 32'h0000_0000, 20'hFFFFF,
               5'd6, 8'h07, 32'hFFFF_F070, 32'hFFFF_F074};
    tbl[3] = '{3'd0, 5'd1, 32'hDEAD_BEEF, 32'hDEAD_BEF3, 20'h00000,
               5'd0, 8'h00, 32'h0000_0000, 32'h0000_0004};

    do_reset();

    for (int i = 0; i < 4; i++) run_trap($sformatf("tbl%0d", i), tbl[i]);

    for (int i = 0; i < 30; i++) run_trap($sformatf("rnd%0d", i), rand_vec());

    // Second request raised during SAVE_L1 and held until taken
    v1 = rand_vec();
    v2 = rand_vec();
    drive_trap(v1);
    step("b2b_a_k0", expect_at(0, v1));
    drive_junk();
    step("b2b_a_k1", expect_at(1, v1));
    drive_trap(v2);
    for (int k = 2; k <= 4; k++) step($sformatf("b2b_a_k%0d", k), expect_at(k, v1));
    step("b2b_b_k0", expect_at(0, v2));
    drive_junk();
    for (int k = 1; k <= 5; k++) step($sformatf("b2b_b_k%0d", k), expect_at(k, v2));

    // Trap with ET=0 enters error mode, which only reset clears
    drive_junk();
    trap_valid = 1'b1; et = 1'b0;
    step("err_req", obs_t'(0));
    e_err = '0;
    e_err.error_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_trap(rand_vec());
      et = (i % 2 == 0);
      step($sformatf("err_hold%0d", i), e_err);
    end
    #2;
    reset = 1'b1;
    #1;
    check("err_async_reset", obs_t'(0));
    @(posedge clk);
    #1;
    reset = 1'b0; trap_valid = 1'b0;
    step("err_after_reset", obs_t'(0));
    run_trap("post_err", tbl[1]);

    // Reset landing in SAVE_L2 abandons the sequence
    v1 = rand_vec();
    drive_trap(v1);
    step("rstl2_k0", expect_at(0, v1));
    drive_junk();
    step("rstl2_k1", expect_at(1, v1));
    step("rstl2_k2", expect_at(2, v1));
    #1;
    reset = 1'b1;
    #1;
    check("rstl2_async", obs_t'(0));
    for (int i = 0; i < 3; i++) step($sformatf("rstl2_hold%0d", i), obs_t'(0));
    reset = 1'b0;
    for (int i = 0; i < 2; i++) step($sformatf("rstl2_idle%0d", i), obs_t'(0));
    run_trap("post_rstl2", rand_vec());

`ifdef TRAP_ENTRY_SEQ_COUNT_EN
    do_reset();
    n_tests++;
    if (trap_count !== 16'd0) begin
      n_fail++;
      $display("FAIL count_reset: got %0d want 0", trap_count);
    end
    for (int i = 0; i < 3; i++) run_trap($sformatf("cnt%0d", i), rand_vec());
    drive_junk();
    trap_valid = 1'b1; et = 1'b0;
    step("cnt_err_req", obs_t'(0));
    step("cnt_err_state", e_err);
    n_tests++;
    if (trap_count !== 16'd3) begin
      n_fail++;
      $display("FAIL count_total: got %0d want 3", trap_count);
    end
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
